// File: rtl/iobus_decode.sv
// -----------------------------------------------------------------------------
// iobus_decode
//
// Port-I/O address decoder that sits behind the CPU I/O byte-serialiser.
// It decodes a 16-bit port address into one of NDEV base/mask windows. It
// forwards the access to the device side as registered strobes with a one-hot
// select, and returns the read data to the bus. Windows flagged in WAITEN
// stretch the access until the device raises dev_ready, or until TIMEOUT wait
// cycles have passed. Unmapped reads and timed-out reads return all ones.
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   bus_address     16-bit port address
//   bus_read/write  one-cycle access strobes from the serialiser
//   bus_datasize    bytes remaining in the serialised access (1..4)
//   bus_writedata   write data, low byte first
//   bus_readdata    registered read data returned to the serialiser
//   bus_io32        combinational: current address takes a single 32-bit access
//   io_wait         registered: a wait-state access is still in progress
//   dev_sel         registered one-hot device select, held for the access
//   dev_address     registered port address
//   dev_read/write  registered one-cycle device strobes
//   dev_writedata   registered write data, forwarded unshifted
//   dev_readdata    per-device read data, slice i = [32i+31:32i]
//   dev_ready       per-device completion; only sampled for WAITEN windows
// -----------------------------------------------------------------------------
module iobus_decode #(
  parameter int                 NDEV    = 4,
  parameter logic [16*NDEV-1:0] BASE    = {NDEV{16'h0000}},
  parameter logic [16*NDEV-1:0] MASK    = {NDEV{16'hFFFF}},
  parameter logic [NDEV-1:0]    IO32    = {NDEV{1'b0}},
  parameter logic [NDEV-1:0]    WAITEN  = {NDEV{1'b0}},
  parameter int unsigned        TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          bus_address,
  input  logic                 bus_read,
  input  logic                 bus_write,
  input  logic [2:0]           bus_datasize,
  input  logic [31:0]          bus_writedata,
  output logic [31:0]          bus_readdata,
  output logic                 bus_io32,
  output logic                 io_wait,
  output logic [NDEV-1:0]      dev_sel,
  output logic [15:0]          dev_address,
  output logic                 dev_read,
  output logic                 dev_write,
  output logic [31:0]          dev_writedata,
  input  logic [32*NDEV-1:0]   dev_readdata,
  input  logic [NDEV-1:0]      dev_ready
);

  localparam int IDXW = (NDEV > 1) ? $clog2(NDEV) : 1;

  // The wait counter times out after it has counted TIMEOUT wait cycles,
  // so the decision is taken while it still holds TIMEOUT-1.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    WAIT
  } state_t;

  state_t            state, state_nxt;

  // Registered state besides the outputs themselves.
  logic [IDXW-1:0]   sel_idx, sel_idx_nxt;     // index of the selected window
  logic              is_read, is_read_nxt;     // access in flight is a read
  logic [15:0]       wait_cnt, wait_cnt_nxt;

  // Next-state values for the registered outputs.
  logic [31:0]       bus_readdata_nxt;
  logic              io_wait_nxt;
  logic [NDEV-1:0]   dev_sel_nxt;
  logic [15:0]       dev_address_nxt;
  logic              dev_read_nxt;
  logic              dev_write_nxt;
  logic [31:0]       dev_writedata_nxt;

  // Address decode results.
  logic              hit_any;
  logic [IDXW-1:0]   hit_idx;
  logic [NDEV-1:0]   hit_oh;
  logic              hit_io32;
  logic              hit_wait;

  // Data and ready of the window latched into sel_idx.
  logic [31:0]       sel_rdata;
  logic              sel_ready;

  // ---------------------------------------------------------------------------
  // Window decode. The loop scans upward and keeps the first hit, so the lowest
  // index wins when windows overlap.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path through the block leaves it unassigned (no latch).
    hit_any  = 1'b0;
    hit_idx  = '0;
    hit_oh   = '0;
    hit_io32 = 1'b0;
    hit_wait = 1'b0;
    for (int i = 0; i < NDEV; i++) begin
      if (!hit_any &&
          ((bus_address & MASK[16*i +: 16]) == (BASE[16*i +: 16] & MASK[16*i +: 16]))) begin
        hit_any   = 1'b1;
        hit_idx   = IDXW'(i);
        hit_oh[i] = 1'b1;
        hit_io32  = IO32[i];
        hit_wait  = WAITEN[i];
      end
    end
  end

  // A 32-bit access is offered only when it is dword aligned and the
  // serialiser still has all four bytes to move.
  assign bus_io32 = hit_any && hit_io32 && (bus_address[1:0] == 2'b00) &&
                    (bus_datasize == 3'd4);

  // Mux the selected device's read data and ready.
  always_comb begin
    sel_rdata = '1;
    sel_ready = 1'b0;
    for (int i = 0; i < NDEV; i++) begin
      if (sel_idx == IDXW'(i)) begin
        sel_rdata = dev_readdata[32*i +: 32];
        sel_ready = dev_ready[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt         = state;
    sel_idx_nxt       = sel_idx;
    is_read_nxt       = is_read;
    wait_cnt_nxt      = wait_cnt;
    bus_readdata_nxt  = bus_readdata;
    io_wait_nxt       = io_wait;
    dev_sel_nxt       = dev_sel;
    dev_address_nxt   = dev_address;
    dev_writedata_nxt = dev_writedata;
    dev_read_nxt      = 1'b0;              // strobes are single-cycle pulses
    dev_write_nxt     = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus_write || bus_read) begin
          // A simultaneous read and write is treated as a write.
          dev_address_nxt   = bus_address;
          dev_writedata_nxt = bus_writedata;
          dev_sel_nxt       = hit_oh;      // all zeros when unmapped
          sel_idx_nxt       = hit_idx;
          is_read_nxt       = !bus_write;
          dev_read_nxt      = hit_any && !bus_write;
          dev_write_nxt     = hit_any && bus_write;
          if (hit_any && hit_wait) begin
            io_wait_nxt  = 1'b1;
            wait_cnt_nxt = '0;
            state_nxt    = WAIT;
          end else begin
            state_nxt    = DATA;
          end
        end
      end

      DATA: begin
        if (is_read) begin
          bus_readdata_nxt = (|dev_sel) ? sel_rdata : 32'hFFFF_FFFF;
        end
        dev_sel_nxt = '0;
        state_nxt   = IDLE;
      end

      WAIT: begin
        // Ready is checked first, so it wins over a timeout in the same cycle.
        if (sel_ready) begin
          if (is_read) begin
            bus_readdata_nxt = sel_rdata;
          end
          io_wait_nxt = 1'b0;
          dev_sel_nxt = '0;
          state_nxt   = IDLE;
        end else if (wait_cnt == TMO_LAST) begin
          // Forced completion: reads see all ones, a write is simply lost.
          if (is_read) begin
            bus_readdata_nxt = 32'hFFFF_FFFF;
          end
          io_wait_nxt = 1'b0;
          dev_sel_nxt = '0;
          state_nxt   = IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + 16'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the values from before the edge, whatever the
    // statement order.
    if (reset) begin
      state         <= IDLE;
      sel_idx       <= '0;
      is_read       <= 1'b0;
      wait_cnt      <= '0;
      bus_readdata  <= 32'hFFFF_FFFF;
      io_wait       <= 1'b0;
      dev_sel       <= '0;
      dev_address   <= '0;
      dev_read      <= 1'b0;
      dev_write     <= 1'b0;
      dev_writedata <= '0;
    end else begin
      state         <= state_nxt;
      sel_idx       <= sel_idx_nxt;
      is_read       <= is_read_nxt;
      wait_cnt      <= wait_cnt_nxt;
      bus_readdata  <= bus_readdata_nxt;
      io_wait       <= io_wait_nxt;
      dev_sel       <= dev_sel_nxt;
      dev_address   <= dev_address_nxt;
      dev_read      <= dev_read_nxt;
      dev_write     <= dev_write_nxt;
      dev_writedata <= dev_writedata_nxt;
    end
  end

  // The upstream stage must hold off new strobes until the decoder is idle.
  // In hardware such strobes are ignored; simulation flags them.
  strobe_while_busy: assert property (@(posedge clk) disable iff (reset)
    (state != IDLE) |-> !(bus_read || bus_write))
    else $error("iobus_decode: bus strobe while an access is in progress");

endmodule
